hsv_blob_tracker: RTL and testbench

- Parametrised successor to the single-colour motion-predict scanner.
- Requests pixel coordinates from the frame-buffer reader, accepts RGB, converts to HSV in a 2-stage pipeline and filters against runtime HSV windows latched at frame start.
- Tracks the up/down/left/right extreme points, pass-pixel count and bounding-box validity; reports once per frame to the game/overlay logic.

---
 rtl/hsv_blob_tracker_if.sv | 18 +
 rtl/hsv_blob_tracker.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_hsv_blob_tracker.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hsv_blob_tracker_if.sv
// Frame-buffer request/response bus for hsv_blob_tracker.
//   req_valid/req_x/req_y : one-cycle coordinate request from the tracker
//   pix_valid/r/g/b       : RGB answer for the outstanding request
// master = tracker side, slave = frame-buffer reader side.
interface hsv_blob_tracker_if #(
  parameter int unsigned CW = 11
);
  logic          req_valid;
  logic [CW-1:0] req_x;
  logic [CW-1:0] req_y;
  logic          pix_valid;
  logic [7:0]    r;
  logic [7:0]    g;
  logic [7:0]    b;

  modport master (output req_valid, req_x, req_y, input pix_valid, r, g, b);
  modport slave  (input req_valid, req_x, req_y, output pix_valid, r, g, b);
endinterface

// File: rtl/hsv_blob_tracker.sv
// HSV colour-blob tracker. Scans a frame by requesting coordinates from the frame-buffer
// reader, converts each RGB answer to HSV in a 2-stage pipeline, filters against HSV windows
// latched at frame start and tracks the up/down/left/right extreme pass pixels.
// Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_start               : frame start pulse (honoured only when idle)
//   i_hmin..i_vmax        : inclusive HSV windows, latched at frame start
//   fb                    : request/pixel bus to the frame-buffer reader
//   o_busy                : high whenever not idle
//   o_valid               : one-cycle result strobe
//   o_found, o_count, o_* : per-frame results, held until the next result strobe
module hsv_blob_tracker #(
  parameter int unsigned WIDTH     = 640,
  parameter int unsigned HEIGHT    = 480,
  parameter int unsigned STRIDE_X  = 1,
  parameter int unsigned STRIDE_Y  = 1,
  parameter int unsigned CW        = 11,
  parameter int unsigned MIN_COUNT = 16,
  parameter int unsigned NOT_FOUND = 2023
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [8:0]          i_hmin,
  input  logic [8:0]          i_hmax,
  input  logic [7:0]          i_smin,
  input  logic [7:0]          i_smax,
  input  logic [7:0]          i_vmin,
  input  logic [7:0]          i_vmax,
  hsv_blob_tracker_if.master  fb,
  output logic                o_busy,
  output logic                o_valid,
  output logic                o_found,
  output logic [CW-1:0]       o_up_x,
  output logic [CW-1:0]       o_up_y,
  output logic [CW-1:0]       o_down_x,
  output logic [CW-1:0]       o_down_y,
  output logic [CW-1:0]       o_left_x,
  output logic [CW-1:0]       o_left_y,
  output logic [CW-1:0]       o_right_x,
  output logic [CW-1:0]       o_right_y,
  output logic [19:0]         o_count
);
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StReq   = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StOut   = 3'd4;

  localparam logic [1:0] ChR = 2'd0;
  localparam logic [1:0] ChG = 2'd1;
  localparam logic [1:0] ChB = 2'd2;

  localparam logic [CW-1:0] NF = CW'(NOT_FOUND);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          drain_q, drain_d;
  logic          start_frame, pix_accept;
  logic [8:0]    hmin_q, hmax_q;
  logic [7:0]    smin_q, smax_q, vmin_q, vmax_q;

  // ---------------- control FSM ----------------
  logic x_wrap, y_last;
  assign x_wrap = (32'(x_q) + STRIDE_X) >= WIDTH;
  assign y_last = (32'(y_q) + STRIDE_Y) >= HEIGHT;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    drain_d     = drain_q;
    start_frame = 1'b0;
    pix_accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_start) begin
          start_frame = 1'b1;
          x_d         = '0;
          y_d         = '0;
          state_d     = StReq;
        end
      end
      StReq: state_d = StWait;
      StWait: begin
        if (fb.pix_valid) begin
          pix_accept = 1'b1;
          if (!x_wrap) begin
            x_d     = x_q + CW'(STRIDE_X);
            state_d = StReq;
          end else begin
            x_d = '0;
            if (!y_last) begin
              y_d     = y_q + CW'(STRIDE_Y);
              state_d = StReq;
            end else begin
              drain_d = 1'b0;
              state_d = StDrain;
            end
          end
        end
      end
      StDrain: begin
        // Two cycles: the last pixel leaves stage 2 and is accumulated.
        drain_d = 1'b1;
        if (drain_q) state_d = StOut;
      end
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      drain_q <= 1'b0;
      hmin_q  <= '0;
      hmax_q  <= '0;
      smin_q  <= '0;
      smax_q  <= '0;
      vmin_q  <= '0;
      vmax_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      drain_q <= drain_d;
      if (start_frame) begin
        hmin_q <= i_hmin;
        hmax_q <= i_hmax;
        smin_q <= i_smin;
        smax_q <= i_smax;
        vmin_q <= i_vmin;
        vmax_q <= i_vmax;
      end
    end
  end

  assign fb.req_valid = (state_q == StReq);
  assign fb.req_x     = x_q;
  assign fb.req_y     = y_q;
  assign o_busy       = (state_q != StIdle);
  assign o_valid      = (state_q == StOut);

  // ---------------- stage 1: max / min / delta / channel-of-max ----------------
  logic [7:0] px_max, px_min;
  logic [1:0] px_ch;

  always_comb begin
    if (fb.r >= fb.g && fb.r >= fb.b) begin
      px_max = fb.r;
      px_ch  = ChR;
    end else if (fb.g >= fb.b) begin
      px_max = fb.g;
      px_ch  = ChG;
    end else begin
      px_max = fb.b;
      px_ch  = ChB;
    end
    px_min = fb.r;
    if (fb.g < px_min) px_min = fb.g;
    if (fb.b < px_min) px_min = fb.b;
  end

  logic          s1_valid_q;
  logic [7:0]    s1_r_q, s1_g_q, s1_b_q, s1_max_q, s1_d_q;
  logic [1:0]    s1_ch_q;
  logic [CW-1:0] s1_x_q, s1_y_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_r_q     <= '0;
      s1_g_q     <= '0;
      s1_b_q     <= '0;
      s1_max_q   <= '0;
      s1_d_q     <= '0;
      s1_ch_q    <= ChR;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else begin
      s1_valid_q <= pix_accept;
      if (pix_accept) begin
        s1_r_q   <= fb.r;
        s1_g_q   <= fb.g;
        s1_b_q   <= fb.b;
        s1_max_q <= px_max;
        s1_d_q   <= px_max - px_min;
        s1_ch_q  <= px_ch;
        s1_x_q   <= x_q;
        s1_y_q   <= y_q;
      end
    end
  end

  // ---------------- stage 2: hue / saturation / value and window test ----------------
  logic signed [16:0] hue_diff, hue_num, hue_den, hue_t;
  logic [8:0]         hue;
  logic [7:0]         sat;
  logic               px_pass;

  always_comb begin
    case (s1_ch_q)
      ChR:     hue_diff = $signed({9'd0, s1_g_q}) - $signed({9'd0, s1_b_q});
      ChG:     hue_diff = $signed({9'd0, s1_b_q}) - $signed({9'd0, s1_r_q});
      default: hue_diff = $signed({9'd0, s1_r_q}) - $signed({9'd0, s1_g_q});
    endcase
    hue_num = hue_diff * 17'sd60;
    // Divisor forced non-zero; the d==0 result is overridden below.
    hue_den = (s1_d_q == 8'd0) ? 17'sd1 : $signed({9'd0, s1_d_q});
    hue_t   = hue_num / hue_den;  // truncates toward zero
    if (s1_d_q == 8'd0) begin
      hue = '0;
    end else begin
      case (s1_ch_q)
        ChR:     hue = (hue_t < 17'sd0) ? 9'(hue_t + 17'sd360) : 9'(hue_t);
        ChG:     hue = 9'(hue_t + 17'sd120);
        default: hue = 9'(hue_t + 17'sd240);
      endcase
    end
    sat = (s1_max_q == 8'd0) ? 8'd0
        : 8'(({8'd0, s1_d_q} * 16'd255) / {8'd0, s1_max_q});
    px_pass = (hue >= hmin_q) && (hue <= hmax_q) &&
              (sat >= smin_q) && (sat <= smax_q) &&
              (s1_max_q >= vmin_q) && (s1_max_q <= vmax_q);
  end

  logic          s2_valid_q, s2_pass_q;
  logic [CW-1:0] s2_x_q, s2_y_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_q <= 1'b0;
      s2_pass_q  <= 1'b0;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_pass_q  <= px_pass;
      s2_x_q     <= s1_x_q;
      s2_y_q     <= s1_y_q;
    end
  end

  // ---------------- accumulators ----------------
  logic [19:0]   cnt_q, cnt_d;
  logic [CW-1:0] up_x_q, up_y_q, dn_x_q, dn_y_q, lf_x_q, lf_y_q, rt_x_q, rt_y_q;
  logic [CW-1:0] up_x_d, up_y_d, dn_x_d, dn_y_d, lf_x_d, lf_y_d, rt_x_d, rt_y_d;
  logic          found_d, res_load;

  always_comb begin
    cnt_d  = cnt_q;
    up_x_d = up_x_q;
    up_y_d = up_y_q;
    dn_x_d = dn_x_q;
    dn_y_d = dn_y_q;
    lf_x_d = lf_x_q;
    lf_y_d = lf_y_q;
    rt_x_d = rt_x_q;
    rt_y_d = rt_y_q;
    if (start_frame) begin
      cnt_d  = '0;
      up_x_d = NF;
      up_y_d = NF;
      dn_x_d = '0;
      dn_y_d = '0;
      lf_x_d = NF;
      lf_y_d = NF;
      rt_x_d = '0;
      rt_y_d = '0;
    end else if (s2_valid_q && s2_pass_q) begin
      if (cnt_q != 20'hFFFFF) cnt_d = cnt_q + 20'd1;
      // Strict/non-strict compares pick first or last pixel on ties.
      if (s2_y_q < up_y_q) begin
        up_x_d = s2_x_q;
        up_y_d = s2_y_q;
      end
      if (s2_y_q >= dn_y_q) begin
        dn_x_d = s2_x_q;
        dn_y_d = s2_y_q;
      end
      if (s2_x_q <= lf_x_q) begin
        lf_x_d = s2_x_q;
        lf_y_d = s2_y_q;
      end
      if (s2_x_q > rt_x_q) begin
        rt_x_d = s2_x_q;
        rt_y_d = s2_y_q;
      end
    end
  end

  // Results are loaded entering OUT from the next-state accumulators, which already include
  // the final pixel, so they are stable during the o_valid cycle.
  assign found_d  = 32'(cnt_d) >= MIN_COUNT;
  assign res_load = (state_q == StDrain) && drain_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= '0;
      up_x_q    <= NF;
      up_y_q    <= NF;
      dn_x_q    <= '0;
      dn_y_q    <= '0;
      lf_x_q    <= NF;
      lf_y_q    <= NF;
      rt_x_q    <= '0;
      rt_y_q    <= '0;
      o_found   <= 1'b0;
      o_count   <= '0;
      o_up_x    <= NF;
      o_up_y    <= NF;
      o_down_x  <= '0;
      o_down_y  <= '0;
      o_left_x  <= NF;
      o_left_y  <= NF;
      o_right_x <= '0;
      o_right_y <= '0;
    end else begin
      cnt_q  <= cnt_d;
      up_x_q <= up_x_d;
      up_y_q <= up_y_d;
      dn_x_q <= dn_x_d;
      dn_y_q <= dn_y_d;
      lf_x_q <= lf_x_d;
      lf_y_q <= lf_y_d;
      rt_x_q <= rt_x_d;
      rt_y_q <= rt_y_d;
      if (res_load) begin
        o_found   <= found_d;
        o_count   <= cnt_d;
        o_up_x    <= found_d ? up_x_d : NF;
        o_up_y    <= found_d ? up_y_d : NF;
        o_down_x  <= found_d ? dn_x_d : NF;
        o_down_y  <= found_d ? dn_y_d : NF;
        o_left_x  <= found_d ? lf_x_d : NF;
        o_left_y  <= found_d ? lf_y_d : NF;
        o_right_x <= found_d ? rt_x_d : NF;
        o_right_y <= found_d ? rt_y_d : NF;
      end
    end
  end
endmodule

// File: tb/tb_hsv_blob_tracker.sv
module tb_hsv_blob_tracker;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int CW = 11;
  localparam int NF = 2023;
  localparam logic [23:0] GREEN = {8'd50, 8'd200, 8'd50};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst_n;
  logic          start [2];
  logic [8:0]    hmin, hmax;
  logic [7:0]    smin, smax, vmin, vmax;
  logic          ovalid [2];
  logic          busy [2];
  logic          found [2];
  logic [19:0]   count [2];
  logic [CW-1:0] up_x [2], up_y [2], dn_x [2], dn_y [2];
  logic [CW-1:0] lf_x [2], lf_y [2], rt_x [2], rt_y [2];

  hsv_blob_tracker_if #(.CW(CW)) fb0 ();
  hsv_blob_tracker_if #(.CW(CW)) fb1 ();

  hsv_blob_tracker #(
    .WIDTH(W), .HEIGHT(H), .STRIDE_X(1), .STRIDE_Y(1), .CW(CW), .MIN_COUNT(1), .NOT_FOUND(NF)
  ) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]),
    .i_hmin(hmin), .i_hmax(hmax), .i_smin(smin), .i_smax(smax), .i_vmin(vmin), .i_vmax(vmax),
    .fb(fb0), .o_busy(busy[0]), .o_valid(ovalid[0]), .o_found(found[0]),
    .o_up_x(up_x[0]), .o_up_y(up_y[0]), .o_down_x(dn_x[0]), .o_down_y(dn_y[0]),
    .o_left_x(lf_x[0]), .o_left_y(lf_y[0]), .o_right_x(rt_x[0]), .o_right_y(rt_y[0]),
    .o_count(count[0])
  );

  hsv_blob_tracker #(
    .WIDTH(W), .HEIGHT(H), .STRIDE_X(2), .STRIDE_Y(2), .CW(CW), .MIN_COUNT(1), .NOT_FOUND(NF)
  ) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]),
    .i_hmin(hmin), .i_hmax(hmax), .i_smin(smin), .i_smax(smax), .i_vmin(vmin), .i_vmax(vmax),
    .fb(fb1), .o_busy(busy[1]), .o_valid(ovalid[1]), .o_found(found[1]),
    .o_up_x(up_x[1]), .o_up_y(up_y[1]), .o_down_x(dn_x[1]), .o_down_y(dn_y[1]),
    .o_left_x(lf_x[1]), .o_left_y(lf_y[1]), .o_right_x(rt_x[1]), .o_right_y(rt_y[1]),
    .o_count(count[1])
  );

  int checks = 0;
  int errors = 0;
  logic [23:0] img [H][W];
  int m_hmin, m_hmax, m_smin, m_smax, m_vmin, m_vmax;
  int e_found, e_count, e_ux, e_uy, e_dx, e_dy, e_lx, e_ly, e_rx, e_ry;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_req(input int sel);
    return (sel == 0) ? fb0.req_valid : fb1.req_valid;
  endfunction
  function automatic int get_rx(input int sel);
    return (sel == 0) ? int'(fb0.req_x) : int'(fb1.req_x);
  endfunction
  function automatic int get_ry(input int sel);
    return (sel == 0) ? int'(fb0.req_y) : int'(fb1.req_y);
  endfunction

  task automatic drive_pix(input int sel, input logic v, input logic [23:0] p);
    if (sel == 0) begin
      fb0.pix_valid = v; fb0.r = p[23:16]; fb0.g = p[15:8]; fb0.b = p[7:0];
    end else begin
      fb1.pix_valid = v; fb1.r = p[23:16]; fb1.g = p[15:8]; fb1.b = p[7:0];
    end
  endtask

  task automatic set_win(input int h0, input int h1, input int s0, input int s1,
                         input int v0, input int v1);
    hmin = 9'(h0); hmax = 9'(h1); smin = 8'(s0); smax = 8'(s1); vmin = 8'(v0); vmax = 8'(v1);
  endtask

  task automatic set_exp(input int f, input int c, input int ux, input int uy, input int dx,
                         input int dy, input int lx, input int ly, input int rx, input int ry);
    e_found = f; e_count = c; e_ux = ux; e_uy = uy; e_dx = dx; e_dy = dy;
    e_lx = lx; e_ly = ly; e_rx = rx; e_ry = ry;
  endtask

  task automatic fill(input logic [23:0] p);
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = p;
  endtask

  // HSV conversion and window test straight from the colour-space definition.
  function automatic bit pix_pass(input logic [23:0] p);
    int r, g, b, mx, mn, d, h, s;
    r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
    mx = (r > g) ? r : g; mx = (b > mx) ? b : mx;
    mn = (r < g) ? r : g; mn = (b < mn) ? b : mn;
    d = mx - mn;
    s = (mx == 0) ? 0 : (255 * d) / mx;
    if (d == 0) h = 0;
    else if (r >= g && r >= b) begin
      h = (60 * (g - b)) / d;
      if (h < 0) h += 360;
    end else if (g >= b) h = 120 + (60 * (b - r)) / d;
    else h = 240 + (60 * (r - g)) / d;
    return h >= m_hmin && h <= m_hmax && s >= m_smin && s <= m_smax &&
           mx >= m_vmin && mx <= m_vmax;
  endfunction

  // Extremes chosen over the list of passing pixels in scan order.
  task automatic model(input int st);
    int qx[$], qy[$];
    int mny, mxy, mnx, mxx;
    for (int y = 0; y < H; y += st)
      for (int x = 0; x < W; x += st)
        if (pix_pass(img[y][x])) begin qx.push_back(x); qy.push_back(y); end
    set_exp(0, qx.size(), NF, NF, NF, NF, NF, NF, NF, NF);
    if (qx.size() >= 1) begin
      e_found = 1;
      mny = qy.min()[0]; mxy = qy.max()[0]; mnx = qx.min()[0]; mxx = qx.max()[0];
      for (int i = qx.size() - 1; i >= 0; i--) if (qy[i] == mny) begin e_ux = qx[i]; e_uy = mny; end
      for (int i = 0; i < qx.size(); i++) if (qy[i] == mxy) begin e_dx = qx[i]; e_dy = mxy; end
      for (int i = 0; i < qx.size(); i++) if (qx[i] == mnx) begin e_lx = mnx; e_ly = qy[i]; end
      if (mxx == 0) begin e_rx = 0; e_ry = 0; end
      else for (int i = qx.size() - 1; i >= 0; i--) if (qx[i] == mxx) begin e_rx = mxx; e_ry = qy[i]; end
    end
  endtask

  task automatic check_results(input int sel, input string tag);
    check({tag, ".found"}, found[sel], e_found);
    check({tag, ".count"}, count[sel], e_count);
    check({tag, ".up_x"}, up_x[sel], e_ux);
    check({tag, ".up_y"}, up_y[sel], e_uy);
    check({tag, ".down_x"}, dn_x[sel], e_dx);
    check({tag, ".down_y"}, dn_y[sel], e_dy);
    check({tag, ".left_x"}, lf_x[sel], e_lx);
    check({tag, ".left_y"}, lf_y[sel], e_ly);
    check({tag, ".right_x"}, rt_x[sel], e_rx);
    check({tag, ".right_y"}, rt_y[sel], e_ry);
  endtask

  task automatic run_frame(input int sel, input int delay, input bit poke, input bit use_model,
                           input string tag);
    int st, nx, exp_n, nreq, t, last_acc, rx, ry;
    bit done;
    st = (sel == 0) ? 1 : 2;
    nx = (W + st - 1) / st;
    exp_n = nx * ((H + st - 1) / st);
    m_hmin = int'(hmin); m_hmax = int'(hmax); m_smin = int'(smin);
    m_smax = int'(smax); m_vmin = int'(vmin); m_vmax = int'(vmax);
    if (use_model) model(st);
    start[sel] = 1'b1;
    @(negedge clk);
    start[sel] = 1'b0;
    // Windows must stay as latched; disturb the live inputs.
    set_win($urandom_range(0, 359), $urandom_range(0, 359), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    nreq = 0; t = 0; done = 0; last_acc = 0;
    while (!done && t < 3000) begin
      if (get_req(sel)) begin
        rx = get_rx(sel); ry = get_ry(sel);
        check($sformatf("%s.req_x%0d", tag, nreq), rx, (nreq % nx) * st);
        check($sformatf("%s.req_y%0d", tag, nreq), ry, (nreq / nx) * st);
        nreq++;
        if (poke) start[sel] = 1'b1;
        drive_pix(sel, 1'b1, ~GREEN);  // presented during REQ, must be ignored
        @(negedge clk); t++;
        start[sel] = 1'b0;
        drive_pix(sel, 1'b0, 24'h0);
        repeat (delay) begin @(negedge clk); t++; end
        drive_pix(sel, 1'b1, img[ry % H][rx % W]);
        last_acc = cyc;
        @(negedge clk); t++;
        drive_pix(sel, 1'b0, 24'h0);
      end else if (ovalid[sel]) begin
        done = 1;
      end else begin
        @(negedge clk); t++;
      end
    end
    check({tag, ".done"}, done, 1);
    if (done) begin
      check({tag, ".latency"}, cyc - last_acc, 3);
      check({tag, ".nreq"}, nreq, exp_n);
      check_results(sel, tag);
      @(negedge clk);
      check({tag, ".valid_drop"}, ovalid[sel], 0);
      check({tag, ".idle"}, busy[sel], 0);
      repeat (3) @(negedge clk);
      check({tag, ".hold_count"}, count[sel], e_count);
    end
  endtask

  initial begin
    int n, t, seen;
    rst_n = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    drive_pix(0, 1'b0, 24'h0);
    drive_pix(1, 1'b0, 24'h0);
    set_win(60, 150, 60, 230, 80, 255);
    repeat (3) @(negedge clk);
    set_exp(0, 0, NF, NF, 0, 0, NF, NF, 0, 0);
    check_results(0, "reset");
    check("reset.busy", busy[0], 0);
    check("reset.valid", ovalid[0], 0);
    check("reset.req", fb0.req_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    fill(24'h0);
    set_win(60, 150, 60, 230, 80, 255);
    set_exp(0, 0, NF, NF, NF, NF, NF, NF, NF, NF);
    run_frame(0, 0, 0, 0, "black");

    img[1][3] = GREEN; img[2][5] = GREEN;
    set_win(60, 150, 60, 230, 80, 255);
    set_exp(1, 2, 3, 1, 5, 2, 3, 1, 5, 2);
    run_frame(0, 0, 0, 0, "two");

    fill(GREEN);
    set_win(60, 150, 60, 230, 80, 255);
    set_exp(1, 32, 0, 0, 7, 3, 0, 3, 7, 0);
    run_frame(0, 0, 0, 0, "all");

    fill(24'h0);
    img[0][1] = {8'd255, 8'd255, 8'd0};
    img[1][2] = {8'd0, 8'd255, 8'd255};
    img[2][3] = {8'd255, 8'd0, 8'd128};
    img[3][4] = {8'd255, 8'd0, 8'd0};
    set_win(60, 150, 0, 255, 1, 255);
    set_exp(1, 1, 1, 0, 1, 0, 1, 0, 1, 0);
    run_frame(0, 0, 0, 0, "hue60");
    set_win(180, 180, 0, 255, 1, 255);
    set_exp(1, 1, 2, 1, 2, 1, 2, 1, 2, 1);
    run_frame(0, 0, 0, 0, "hue180");
    set_win(300, 359, 0, 255, 1, 255);
    set_exp(1, 1, 3, 2, 3, 2, 3, 2, 3, 2);
    run_frame(0, 0, 0, 0, "hue330");
    set_win(0, 0, 0, 255, 1, 255);
    set_exp(1, 1, 4, 3, 4, 3, 4, 3, 4, 3);
    run_frame(0, 0, 0, 0, "hue0");

    fill(GREEN);
    set_win(60, 150, 60, 230, 80, 255);
    set_exp(1, 8, 0, 0, 6, 2, 0, 2, 6, 0);
    run_frame(1, 0, 0, 0, "stride");
    set_win(60, 150, 60, 230, 80, 255);
    run_frame(1, 5, 0, 0, "stride_slow");

    set_win(60, 150, 60, 230, 80, 255);
    set_exp(1, 32, 0, 0, 7, 3, 0, 3, 7, 0);
    run_frame(0, 1, 1, 0, "poke");

    // Abandon a frame while waiting on the third pixel.
    set_win(60, 150, 60, 230, 80, 255);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0; t = 0;
    while (n < 3 && t < 100) begin
      if (get_req(0)) begin
        n++;
        @(negedge clk); t++;
        if (n < 3) begin
          drive_pix(0, 1'b1, GREEN);
          @(negedge clk); t++;
          drive_pix(0, 1'b0, 24'h0);
        end
      end else begin
        @(negedge clk); t++;
      end
    end
    check("rst.reached_wait", n, 3);
    #1 rst_n = 1'b0;
    #1;
    set_exp(0, 0, NF, NF, 0, 0, NF, NF, 0, 0);
    check_results(0, "rst");
    check("rst.busy", busy[0], 0);
    check("rst.req", fb0.req_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ovalid[0] || busy[0]) seen++;
    end
    check("rst.no_valid", seen, 0);
    set_win(60, 150, 60, 230, 80, 255);
    set_exp(1, 32, 0, 0, 7, 3, 0, 3, 7, 0);
    run_frame(0, 0, 0, 0, "after_rst");

    for (int i = 0; i < 8; i++) begin
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          if ($urandom_range(0, 1) == 1)
            img[y][x] = {8'($urandom_range(0, 90)), 8'($urandom_range(140, 255)),
                         8'($urandom_range(0, 90))};
          else
            img[y][x] = 24'($urandom);
      set_win($urandom_range(0, 180), $urandom_range(180, 359), $urandom_range(0, 100),
              $urandom_range(150, 255), $urandom_range(0, 100), $urandom_range(150, 255));
      run_frame(i % 2, $urandom_range(0, 3), 0, 1, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
